// File: rtl/adbg_cpu_dbg_arbiter.sv
// -----------------------------------------------------------------------------
// adbg_cpu_dbg_arbiter
// Round-robin arbiter that shares one core debug register port (16-bit
// address, 32-bit data, stb/we/ack) among NB_REQ masters such as the JTAG
// debug BIU and an on-chip trace or self-test master. The winning master's
// command is latched and driven to the core until it acknowledges. The read
// data and a one-cycle ack are then returned to that master. Everything runs
// in the cpu_clk_i domain.
//
// Optional build macro:
//   ADBG_ARB_TIMEOUT_EN - adds a BUSY watchdog. After TIMEOUT_CYCLES cycles
//                         with no cpu_ack_i, the transaction completes with
//                         req_err_o=1 and read data 32'hDEADBEEF. When the
//                         macro is not defined, BUSY waits forever and
//                         req_err_o is tied low.
// -----------------------------------------------------------------------------
module adbg_cpu_dbg_arbiter #(
    parameter int NB_REQ         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   cpu_clk_i,
    input  logic                   trstn_i,
    input  logic [NB_REQ-1:0]      req_stb_i,
    input  logic [NB_REQ-1:0]      req_we_i,
    input  logic [NB_REQ*16-1:0]   req_addr_i,
    input  logic [NB_REQ*32-1:0]   req_data_i,
    output logic [NB_REQ-1:0]      req_ack_o,
    output logic                   req_err_o,
    output logic [31:0]            req_data_o,
    output logic [NB_REQ-1:0]      grant_o,
    output logic [15:0]            cpu_addr_o,
    output logic [31:0]            cpu_data_o,
    output logic                   cpu_stb_o,
    output logic                   cpu_we_o,
    input  logic [31:0]            cpu_data_i,
    input  logic                   cpu_ack_i
);

    // Width of the round-robin pointer; NB_REQ is at least 2, so this is >= 1.
    localparam int PTR_W = $clog2(NB_REQ);

    // Main sequencer states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // A misconfigured instance should stop at elaboration, not misbehave silently.
    if (NB_REQ < 2) begin : g_bad_nb_req
        $error("adbg_cpu_dbg_arbiter: NB_REQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("adbg_cpu_dbg_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_last;
    logic [NB_REQ-1:0] r_grant;
    logic [15:0]       r_cmd_addr;
    logic [31:0]       r_cmd_data;
    logic              r_cmd_we;
    logic [31:0]       r_rdata;

    logic              w_any_req;
    logic [PTR_W-1:0]  w_winner;
    logic [NB_REQ-1:0] w_winner_oh;
    logic [15:0]       w_sel_addr;
    logic [31:0]       w_sel_data;
    logic              w_sel_we;
    logic              w_busy;
    logic              w_done;
    logic              w_start;
    logic              w_timeout;
    logic              w_err;

    // Index of the master that is 'offset' places after 'base', wrapping at NB_REQ.
    function automatic logic [PTR_W-1:0] rrIndex(input logic [PTR_W-1:0] base,
                                                 input int offset);
        int sum;
        sum = (int'(base) + offset) % NB_REQ;
        return PTR_W'(sum);
    endfunction

    // Round-robin pick: scan from the master after the last winner, and let the
    // last winner itself be considered only at the very end.
    always_comb begin
        w_any_req = 1'b0;
        w_winner  = '0;
        for (int k = 1; k <= NB_REQ; k++) begin
            if (!w_any_req && req_stb_i[rrIndex(r_last, k)]) begin
                w_any_req = 1'b1;
                w_winner  = rrIndex(r_last, k);
            end
        end
    end

    // Winner one-hot and a mux of the winner's command fields, ready for latching.
    always_comb begin
        w_winner_oh           = '0;
        w_winner_oh[w_winner] = 1'b1;
        w_sel_addr            = req_addr_i[int'(w_winner)*16 +: 16];
        w_sel_data            = req_data_i[int'(w_winner)*32 +: 32];
        w_sel_we              = req_we_i[w_winner];
    end

    // State decodes that are shared by the sequencer, the watchdog and the outputs.
    always_comb begin
        w_busy  = (r_state == S_BUSY);
        w_done  = (r_state == S_DONE);
        w_start = (r_state == S_IDLE) && w_any_req;
    end

`ifdef ADBG_ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_err;

    // The watchdog fires on the BUSY cycle that would take the count to TIMEOUT_CYCLES.
    always_comb begin
        w_timeout = w_busy && !cpu_ack_i && ((int'(r_tmo_cnt) + 1) >= TIMEOUT_CYCLES);
    end

    // The count restarts with each new grant and advances once per unacknowledged BUSY cycle.
    always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_tmo_cnt <= '0;
        end else if (w_start) begin
            r_tmo_cnt <= '0;
        end else if (w_busy && !cpu_ack_i && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    // Record how BUSY ended, so the DONE cycle can report a timeout. A real ack wins a tie.
    always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_err <= 1'b0;
        end else if (w_busy) begin
            if (cpu_ack_i) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // The error flag is shown only alongside the completion pulse.
    always_comb begin
        w_err = w_done && r_err;
    end
`else
    // Without the watchdog, BUSY can only end on a core ack, and nothing is ever flagged.
    always_comb begin
        w_timeout = 1'b0;
        w_err     = 1'b0;
    end
`endif

    // IDLE -> BUSY -> DONE -> IDLE sequencer. It also holds the command, the owner and the returned data.
    always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_state    <= S_IDLE;
            r_last     <= PTR_W'(NB_REQ - 1);
            r_grant    <= '0;
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
            r_cmd_we   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cmd_addr <= w_sel_addr;
                        r_cmd_data <= w_sel_data;
                        r_cmd_we   <= w_sel_we;
                        r_grant    <= w_winner_oh;
                        r_last     <= w_winner;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cpu_ack_i) begin
                        if (!r_cmd_we) begin
                            r_rdata <= cpu_data_i;
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_rdata <= 32'hDEADBEEF;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The core port is driven only while BUSY, so it reads as all-zero at every other time.
    always_comb begin
        cpu_stb_o  = w_busy;
        cpu_we_o   = w_busy && r_cmd_we;
        cpu_addr_o = w_busy ? r_cmd_addr : 16'h0000;
        cpu_data_o = w_busy ? r_cmd_data : 32'h0000_0000;
    end

    // Master-side outputs: the ack pulse goes only to the owner, and only in DONE.
    always_comb begin
        req_ack_o  = w_done ? r_grant : '0;
        req_err_o  = w_err;
        req_data_o = r_rdata;
        grant_o    = r_grant;
    end

endmodule

// File: tb/tb_adbg_cpu_dbg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adbg_cpu_dbg_arbiter
// Two arbiter instances: a 2-master one driven by simple master/core models,
// and a 4-master one used for the wrap-around priority case. Expected
// completions are queued when requests are issued, and monitors pop them
// whenever an ack appears.
// -----------------------------------------------------------------------------
module tb_adbg_cpu_dbg_arbiter;

    typedef struct {
        int          master;
        logic        err;
        logic [31:0] data;
    } expT;

    logic        clk;
    logic        trstn;

    // 2-master instance
    int          issueCnt [2] = '{0, 0};
    int          doneCnt  [2] = '{0, 0};
    logic [1:0]  stb;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  reqAck;
    logic        reqErr;
    logic [31:0] reqData;
    logic [1:0]  grant;
    logic [15:0] cpuAddr;
    logic [31:0] cpuWdata;
    logic        cpuStb;
    logic        cpuWe;
    logic [31:0] cpuRdata;
    logic        cpuAck;

    // 4-master instance
    logic [3:0]   stb4;
    logic [3:0]   we4;
    logic [63:0]  addr4;
    logic [127:0] wdata4;
    logic [3:0]   ack4;
    logic         err4;
    logic [31:0]  reqData4;
    logic [3:0]   grant4;
    logic [15:0]  cpuAddr4;
    logic [31:0]  cpuWdata4;
    logic         cpuStb4;
    logic         cpuWe4;
    logic [31:0]  cpuRdata4;
    logic         cpuAck4;

    // Core model controls, bookkeeping and scoreboard
    int          ackDelay = 0;
    bit          noAck    = 1'b0;
    logic [31:0] coreData = 32'h0;
    logic [31:0] lastRead = 32'h0;
    int          ackSeen [2] = '{0, 0};
    expT         expQ[$];
    int          exp4Q[$];
    int          testsRun = 0;
    int          failures = 0;

    assign stb[0] = (issueCnt[0] != doneCnt[0]);
    assign stb[1] = (issueCnt[1] != doneCnt[1]);

    adbg_cpu_dbg_arbiter #(.NB_REQ(2), .TIMEOUT_CYCLES(8)) u_dut2 (
        .cpu_clk_i  (clk),
        .trstn_i    (trstn),
        .req_stb_i  (stb),
        .req_we_i   (we),
        .req_addr_i (addr),
        .req_data_i (wdata),
        .req_ack_o  (reqAck),
        .req_err_o  (reqErr),
        .req_data_o (reqData),
        .grant_o    (grant),
        .cpu_addr_o (cpuAddr),
        .cpu_data_o (cpuWdata),
        .cpu_stb_o  (cpuStb),
        .cpu_we_o   (cpuWe),
        .cpu_data_i (cpuRdata),
        .cpu_ack_i  (cpuAck)
    );

    adbg_cpu_dbg_arbiter #(.NB_REQ(4), .TIMEOUT_CYCLES(8)) u_dut4 (
        .cpu_clk_i  (clk),
        .trstn_i    (trstn),
        .req_stb_i  (stb4),
        .req_we_i   (we4),
        .req_addr_i (addr4),
        .req_data_i (wdata4),
        .req_ack_o  (ack4),
        .req_err_o  (err4),
        .req_data_o (reqData4),
        .grant_o    (grant4),
        .cpu_addr_o (cpuAddr4),
        .cpu_data_o (cpuWdata4),
        .cpu_stb_o  (cpuStb4),
        .cpu_we_o   (cpuWe4),
        .cpu_data_i (cpuRdata4),
        .cpu_ack_i  (cpuAck4)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and record the result
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Queue the completion a transaction should produce, tracking the held read data
    task automatic pushExp(input int m, input bit isWrite, input logic [31:0] rd,
                           input bit isErr);
        expT e;
        if (isErr)         lastRead = 32'hDEADBEEF;
        else if (!isWrite) lastRead = rd;
        e.master = m;
        e.err    = isErr;
        e.data   = lastRead;
        expQ.push_back(e);
    endtask

    // Load a command into master m and raise its request for 'count' transactions
    task automatic applyStimulus(input int m, input bit isWrite, input logic [15:0] a,
                                 input logic [31:0] d, input int count);
        we[m]            = isWrite;
        addr[m*16 +: 16] = a;
        wdata[m*32 +: 32] = d;
        issueCnt[m]      = issueCnt[m] + count;
    endtask

    // Wait for the 2-master scoreboard to empty, within a cycle budget
    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    // Wait until the 4-master queue shrinks to 'target' entries, within a budget
    task automatic waitQ4(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (exp4Q.size() > target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(exp4Q.size()), 32'(target));
    endtask

    // Core model for the 2-master instance: ack after ackDelay BUSY cycles unless noAck is set
    initial begin : coreModel
        int busyCnt;
        busyCnt  = 0;
        cpuAck   = 1'b0;
        cpuRdata = 32'h0;
        forever begin
            @(negedge clk);
            if (cpuStb && !noAck) begin
                if (busyCnt >= ackDelay) begin
                    cpuAck   = 1'b1;
                    cpuRdata = coreData;
                end else begin
                    cpuAck = 1'b0;
                    busyCnt++;
                end
            end else begin
                cpuAck  = 1'b0;
                busyCnt = 0;
            end
        end
    end

    // Core model for the 4-master instance: always ack in the first BUSY cycle
    initial begin : core4Model
        cpuAck4   = 1'b0;
        cpuRdata4 = 32'h4444_0000;
        forever begin
            @(negedge clk);
            cpuAck4 = cpuStb4;
        end
    end

    // Masters drop their request at the first ack they see. Reset abandons outstanding requests.
    initial begin : masterModel
        forever begin
            @(negedge clk);
            if (!trstn) begin
                doneCnt[0] = issueCnt[0];
                doneCnt[1] = issueCnt[1];
            end else begin
                for (int m = 0; m < 2; m++) begin
                    if (reqAck[m]) doneCnt[m] = doneCnt[m] + 1;
                end
            end
        end
    end

    // Monitor for the 2-master instance: each ack must match the next queued completion
    initial begin : monitor2
        expT e;
        forever begin
            @(negedge clk);
            if (reqAck != 2'b00) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    failures++;
                    $display("[TB] FAIL unexpectedAck: got req_ack_o=%b, expected none", reqAck);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ackOneHot", {30'b0, reqAck}, 32'd1 << e.master);
                    checkOutput("grantAtAck", {30'b0, grant}, 32'd1 << e.master);
                    checkOutput("errFlag", {31'b0, reqErr}, {31'b0, e.err});
                    checkOutput("reqData", reqData, e.data);
                end
                for (int m = 0; m < 2; m++) begin
                    if (reqAck[m]) ackSeen[m] = ackSeen[m] + 1;
                end
            end
        end
    end

    // Monitor for the 4-master instance: checks the grant order
    initial begin : monitor4
        int m;
        forever begin
            @(negedge clk);
            if (ack4 != 4'b0000) begin
                if (exp4Q.size() == 0) begin
                    testsRun++;
                    failures++;
                    $display("[TB] FAIL unexpectedAck4: got req_ack_o=%b, expected none", ack4);
                end else begin
                    m = exp4Q.pop_front();
                    checkOutput("ack4Order", {28'b0, ack4}, 32'd1 << m);
                    checkOutput("grant4AtAck", {28'b0, grant4}, 32'd1 << m);
                end
            end
        end
    end

    // Directed test sequence
    initial begin : mainSeq
        int a0;
        int a1;
        bit ok;
        bit ok2;
        int busyCycles;
        int n;

        trstn  = 1'b0;
        we     = 2'b00;
        addr   = 32'h0;
        wdata  = 64'h0;
        stb4   = 4'b0000;
        we4    = 4'b0000;
        addr4  = 64'h0004_0003_0002_0001;
        wdata4 = 128'h0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstCpuStb", {31'b0, cpuStb}, 32'd0);
        checkOutput("rstGrant", {30'b0, grant}, 32'd0);
        checkOutput("rstAck", {30'b0, reqAck}, 32'd0);
        checkOutput("rstReqData", reqData, 32'd0);
        checkOutput("rstErr", {31'b0, reqErr}, 32'd0);
        checkOutput("rstCpuAddr", {16'b0, cpuAddr}, 32'd0);
        @(negedge clk);
        trstn = 1'b1;

        // Test 1: master0 read, ack in the first BUSY cycle
        @(negedge clk);
        coreData = 32'hCAFE0001;
        ackDelay = 0;
        pushExp(0, 1'b0, 32'hCAFE0001, 1'b0);
        applyStimulus(0, 1'b0, 16'h0010, 32'h0, 1);
        @(negedge clk);
        checkOutput("t1CpuStb", {31'b0, cpuStb}, 32'd1);
        checkOutput("t1CpuAddr", {16'b0, cpuAddr}, 32'h0010);
        checkOutput("t1CpuWe", {31'b0, cpuWe}, 32'd0);
        checkOutput("t1Grant", {30'b0, grant}, 32'd1);
        @(negedge clk);
        checkOutput("t1StbOneCycle", {31'b0, cpuStb}, 32'd0);
        checkOutput("t1AckLatency", {30'b0, reqAck}, 32'd1);
        @(negedge clk);
        checkOutput("t1AckSingle", {30'b0, reqAck}, 32'd0);
        checkOutput("t1GrantIdle", {30'b0, grant}, 32'd0);
        waitDrain("t1Drain", 10);

        // Test 2: master1 write with a slow core; command held steady, read data kept
        @(negedge clk);
        coreData = 32'hFFFF_FFFF;
        ackDelay = 4;
        pushExp(1, 1'b1, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 16'h0020, 32'h12345678, 1);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(cpuStb && cpuWe && cpuAddr == 16'h0020 && cpuWdata == 32'h12345678))
                ok = 1'b0;
        end
        checkOutput("t2BusyStable", {31'b0, ok}, 32'd1);
        @(negedge clk);
        checkOutput("t2StbDropped", {31'b0, cpuStb}, 32'd0);
        checkOutput("t2Ack", {30'b0, reqAck}, 32'd2);
        waitDrain("t2Drain", 10);

        // Test 3: both masters request continuously; strict alternation starting at 0
        @(negedge clk);
        ackDelay = 0;
        coreData = 32'h0BADF00D;
        a0 = ackSeen[0];
        a1 = ackSeen[1];
        for (int i = 0; i < 20; i++) begin
            pushExp(i % 2, (i % 2) == 1, 32'h0BADF00D, 1'b0);
        end
        applyStimulus(0, 1'b0, 16'h0030, 32'h0, 10);
        applyStimulus(1, 1'b1, 16'h0031, 32'h11110000, 10);
        waitDrain("t3Drain", 200);
        checkOutput("t3AcksM0", 32'(ackSeen[0] - a0), 32'd10);
        checkOutput("t3AcksM1", 32'(ackSeen[1] - a1), 32'd10);

        // Test 4: 4 masters; serve 3, then requests from 1 and 3 wrap to 1 first
        @(negedge clk);
        exp4Q.push_back(3);
        stb4[3] = 1'b1;
        waitQ4("t4First", 0, 20);
        stb4[3] = 1'b0;
        @(negedge clk);
        exp4Q.push_back(1);
        exp4Q.push_back(3);
        stb4 = 4'b1010;
        waitQ4("t4SecondM1", 1, 20);
        stb4[1] = 1'b0;
        waitQ4("t4ThirdM3", 0, 20);
        stb4[3] = 1'b0;

        // Test 5: reset while BUSY aborts silently; afterwards master0 has priority
        @(negedge clk);
        noAck = 1'b1;
        applyStimulus(1, 1'b0, 16'h0040, 32'h0, 1);
        repeat (3) @(negedge clk);
        checkOutput("t5BusyBefore", {31'b0, cpuStb}, 32'd1);
        checkOutput("t5GrantBefore", {30'b0, grant}, 32'd2);
        trstn = 1'b0;
        #1;
        checkOutput("t5StbAsyncDrop", {31'b0, cpuStb}, 32'd0);
        checkOutput("t5GrantAsyncDrop", {30'b0, grant}, 32'd0);
        checkOutput("t5NoAck", {30'b0, reqAck}, 32'd0);
        repeat (2) @(negedge clk);
        lastRead = 32'h0;
        checkOutput("t5DataCleared", reqData, 32'd0);
        trstn = 1'b1;
        noAck = 1'b0;
        @(negedge clk);
        coreData = 32'h77770005;
        pushExp(0, 1'b0, 32'h77770005, 1'b0);
        pushExp(1, 1'b0, 32'h77770005, 1'b0);
        applyStimulus(0, 1'b0, 16'h0050, 32'h0, 1);
        applyStimulus(1, 1'b0, 16'h0051, 32'h0, 1);
        waitDrain("t5Drain", 20);

        // Test 6: the core never acks
        @(negedge clk);
        noAck = 1'b1;
`ifdef ADBG_ARB_TIMEOUT_EN
        pushExp(0, 1'b0, 32'h0, 1'b1);
        applyStimulus(0, 1'b0, 16'h0060, 32'h0, 1);
        busyCycles = 0;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            if (cpuStb) busyCycles++;
            #1;
            n++;
        end
        checkOutput("t6TimeoutCycles", 32'(busyCycles), 32'd8);
        waitDrain("t6Drain", 5);
`else
        applyStimulus(0, 1'b0, 16'h0060, 32'h0, 1);
        @(negedge clk);
        ok  = 1'b1;
        ok2 = 1'b1;
        busyCycles = 0;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (!cpuStb) ok = 1'b0;
            if (reqAck != 2'b00) ok2 = 1'b0;
        end
        checkOutput("t6StbHeld", {31'b0, ok}, 32'd1);
        checkOutput("t6NoAck", {31'b0, ok2}, 32'd1);
        trstn = 1'b0;
        repeat (2) @(negedge clk);
        trstn = 1'b1;
        lastRead = 32'h0;
`endif
        noAck = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("endQueue4Empty", 32'(exp4Q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
